// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder
// Output reorder buffer for a radix-2 DIF SDF FFT. Samples arrive one per
// cycle in bit-reversed bin order. Each N-point frame leaves in natural order
// (bin 0..N-1). Two banks ping-pong: one fills while the other drains, so
// throughput is sustained at one sample per cycle.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   din_valid / din_ready    input handshake; din_ready depends only on registers
//   din_real, din_imag       input sample components (signed, DATA_WIDTH bits)
//   dout_valid / dout_ready  output handshake; dout_* hold steady while stalled
//   dout_real, dout_imag     output sample components
//   dout_sop, dout_eop       flag bin 0 and bin N-1 of each output frame
module fft_bitrev_reorder #(
    parameter int DATA_WIDTH = 12,
    parameter int LOG2_N     = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [DATA_WIDTH-1:0] din_real,
    input  logic [DATA_WIDTH-1:0] din_imag,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [DATA_WIDTH-1:0] dout_real,
    output logic [DATA_WIDTH-1:0] dout_imag,
    output logic                  dout_sop,
    output logic                  dout_eop
);

    localparam int                N        = 1 << LOG2_N;
    localparam int                WORD_W   = 2 * DATA_WIDTH;
    localparam logic [LOG2_N-1:0] CNT_ZERO = {LOG2_N{1'b0}};
    localparam logic [LOG2_N-1:0] CNT_ONE  = LOG2_N'(1);
    localparam logic [LOG2_N-1:0] CNT_LAST = LOG2_N'(N - 1);

    // Mirror the LOG2_N address bits (bit k -> bit LOG2_N-1-k).
    function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] idx);
        logic [LOG2_N-1:0] rev;
        rev = CNT_ZERO;
        for (int k = 0; k < LOG2_N; k++) begin
            rev[LOG2_N-1-k] = idx[k];
        end
        return rev;
    endfunction

    // Bank select is the MSB of the address: {bank, index}.
    logic [WORD_W-1:0]     mem_r [2*N];

    logic                  wr_bank_r;
    logic                  rd_bank_r;
    logic [LOG2_N-1:0]     wr_cnt_r;
    logic [LOG2_N-1:0]     rd_cnt_r;
    logic [1:0]            full_r;

    logic                  dout_valid_r;
    logic [DATA_WIDTH-1:0] dout_real_r;
    logic [DATA_WIDTH-1:0] dout_imag_r;
    logic                  dout_sop_r;
    logic                  dout_eop_r;

    logic                  din_ready_s;
    logic                  wr_en_s;
    logic                  wr_last_s;
    logic                  rd_last_s;
    logic                  load_s;
    logic [LOG2_N:0]       wr_addr_s;
    logic [LOG2_N:0]       rd_addr_s;
    logic [WORD_W-1:0]     rd_word_s;
    logic [1:0]            set_mask_s;
    logic [1:0]            clr_mask_s;
    logic [1:0]            full_nxt_s;

    // A write bank is free until its last entry has been written; a read
    // bank is loadable once full and the output register can take a sample.
    assign din_ready_s = ~full_r[wr_bank_r];
    assign wr_en_s     = din_valid & din_ready_s;
    assign wr_last_s   = (wr_cnt_r == CNT_LAST);
    assign rd_last_s   = (rd_cnt_r == CNT_LAST);
    assign load_s      = full_r[rd_bank_r] & (~dout_valid_r | dout_ready);
    assign wr_addr_s   = {wr_bank_r, wr_cnt_r};
    assign rd_addr_s   = {rd_bank_r, bitrev(rd_cnt_r)};
    assign rd_word_s   = mem_r[rd_addr_s];

    assign din_ready  = din_ready_s;
    assign dout_valid = dout_valid_r;
    assign dout_real  = dout_real_r;
    assign dout_imag  = dout_imag_r;
    assign dout_sop   = dout_sop_r;
    assign dout_eop   = dout_eop_r;

    // Next bank-full flags. A set (write bank completes) and a clear (read
    // bank drains) on the same edge always address different banks.
    always_comb begin
        set_mask_s = 2'b00;
        clr_mask_s = 2'b00;
        if (wr_en_s && wr_last_s) begin
            set_mask_s[wr_bank_r] = 1'b1;
        end else begin
            set_mask_s = 2'b00;
        end
        if (load_s && rd_last_s) begin
            clr_mask_s[rd_bank_r] = 1'b1;
        end else begin
            clr_mask_s = 2'b00;
        end
        full_nxt_s = (full_r | set_mask_s) & ~clr_mask_s;
    end

    // Sample storage; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_addr_s] <= {din_real, din_imag};
        end
    end

    // Bank-full flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_r <= 2'b00;
        end else begin
            full_r <= full_nxt_s;
        end
    end

    // Write pointer: advance on each accepted sample, switch bank at frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_r <= 1'b0;
            wr_cnt_r  <= CNT_ZERO;
        end else if (wr_en_s) begin
            if (wr_last_s) begin
                wr_bank_r <= ~wr_bank_r;
                wr_cnt_r  <= CNT_ZERO;
            end else begin
                wr_cnt_r  <= wr_cnt_r + CNT_ONE;
            end
        end
    end

    // Read pointer and output register: load the next natural-order bin when
    // the register is empty or being consumed, otherwise hold it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_bank_r    <= 1'b0;
            rd_cnt_r     <= CNT_ZERO;
            dout_valid_r <= 1'b0;
            dout_real_r  <= {DATA_WIDTH{1'b0}};
            dout_imag_r  <= {DATA_WIDTH{1'b0}};
            dout_sop_r   <= 1'b0;
            dout_eop_r   <= 1'b0;
        end else if (load_s) begin
            dout_valid_r <= 1'b1;
            dout_real_r  <= rd_word_s[WORD_W-1:DATA_WIDTH];
            dout_imag_r  <= rd_word_s[DATA_WIDTH-1:0];
            dout_sop_r   <= (rd_cnt_r == CNT_ZERO);
            dout_eop_r   <= rd_last_s;
            if (rd_last_s) begin
                rd_bank_r <= ~rd_bank_r;
                rd_cnt_r  <= CNT_ZERO;
            end else begin
                rd_cnt_r  <= rd_cnt_r + CNT_ONE;
            end
        end else if (dout_ready) begin
            dout_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Testbench for fft_bitrev_reorder. Main instance uses N=8; a second N=64
// instance exercises full-range signed values.
module tb_fft_bitrev_reorder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [11:0] din_real = 12'd0;
    logic [11:0] din_imag = 12'd0;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic [11:0] dout_real;
    logic [11:0] dout_imag;
    logic        dout_sop;
    logic        dout_eop;

    logic        d6_din_valid = 1'b0;
    logic        d6_din_ready;
    logic [11:0] d6_din_real = 12'd0;
    logic [11:0] d6_din_imag = 12'd0;
    logic        d6_dout_valid;
    logic        d6_dout_ready = 1'b1;
    logic [11:0] d6_dout_real;
    logic [11:0] d6_dout_imag;
    logic        d6_dout_sop;
    logic        d6_dout_eop;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ready_mode = 1;     // 0 = low, 1 = high, 2 = random 50%
    bit t2_window = 1'b0;
    bit gap_window = 1'b0;
    int drops = 0;
    int gaps = 0;
    int win_outs = 0;

    logic [25:0] exp_q[$];  // {real, imag, sop, eop}
    logic [23:0] fbuf[$];   // current partial input frame in arrival order

    fft_bitrev_reorder #(.DATA_WIDTH(12), .LOG2_N(3)) dut (
        .clk(clk), .rst(rst),
        .din_valid(din_valid), .din_ready(din_ready),
        .din_real(din_real), .din_imag(din_imag),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_real(dout_real), .dout_imag(dout_imag),
        .dout_sop(dout_sop), .dout_eop(dout_eop)
    );

    fft_bitrev_reorder #(.DATA_WIDTH(12), .LOG2_N(6)) dut64 (
        .clk(clk), .rst(rst),
        .din_valid(d6_din_valid), .din_ready(d6_din_ready),
        .din_real(d6_din_real), .din_imag(d6_din_imag),
        .dout_valid(d6_dout_valid), .dout_ready(d6_dout_ready),
        .dout_real(d6_dout_real), .dout_imag(d6_dout_imag),
        .dout_sop(d6_dout_sop), .dout_eop(d6_dout_eop)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    function automatic int brev(input int v, input int bits);
        int r = 0;
        int x = v;
        for (int i = 0; i < bits; i++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: input position p carries bin brev(p); output bins 0..7 in order.
    task automatic model_accept(input logic [11:0] re, input logic [11:0] im);
        fbuf.push_back({re, im});
        if (fbuf.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                exp_q.push_back({fbuf[brev(k, 3)], (k == 0), (k == 7)});
            end
            fbuf.delete();
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [11:0] re, input logic [11:0] im);
        int waitc = 0;
        din_real  = re;
        din_imag  = im;
        din_valid = 1'b1;
        while (!din_ready && waitc < 500) begin
            @(negedge clk);
            waitc++;
        end
        if (!din_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=stalled required=accept");
        end else begin
            model_accept(re, im);
        end
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
        @(negedge clk);
    endtask

    // Downstream ready driver, changes just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       dout_ready = 1'b0;
                1:       dout_ready = 1'b1;
                default: dout_ready = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    // Monitor: pops the scoreboard on every output transfer, checks hold-stability.
    initial begin
        logic        hold_v;
        logic [26:0] held;
        logic [25:0] e;
        int          last_cyc;
        bit          gap_seen;
        hold_v = 1'b0;
        held = 27'd0;
        last_cyc = 0;
        gap_seen = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!gap_window) gap_seen = 1'b0;
            if (!rst) begin
                if (hold_v) chk("stall_stable", {dout_valid, dout_real, dout_imag, dout_sop, dout_eop}, held);
                if (t2_window && !din_ready) drops++;
                if (dout_valid && dout_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output actual=%0h required=none", {dout_real, dout_imag});
                    end else begin
                        e = exp_q.pop_front();
                        chk("dout", {dout_real, dout_imag, dout_sop, dout_eop}, e);
                    end
                    if (gap_window) begin
                        if (gap_seen && cyc != last_cyc + 1) gaps++;
                        gap_seen = 1'b1;
                        last_cyc = cyc;
                        win_outs++;
                    end
                end
                hold_v = dout_valid && !dout_ready;
                held = {dout_valid, dout_real, dout_imag, dout_sop, dout_eop};
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    initial begin
        int acc;
        int n;
        int v6;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_dout", {dout_valid, dout_sop, dout_eop, dout_real, dout_imag}, 0);
        chk("rst_din_ready", din_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // Test 1: single frame, latency and bitrev order
        for (int i = 0; i < 8; i++) send(12'(i), 12'(0 - i));
        chk("lat_pre", dout_valid, 0);
        @(negedge clk);
        chk("lat_bin0", {dout_valid, dout_real, dout_sop}, {1'b1, 12'd0, 1'b1});
        wait_drain("t1_drain", 100);

        // Test 2: three contiguous frames, both sides always ready
        drops = 0; gaps = 0; win_outs = 0;
        t2_window = 1'b1;
        gap_window = 1'b1;
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 8; i++) send(12'(f * 8 + i), 12'($urandom));
        t2_window = 1'b0;
        wait_drain("t2_drain", 100);
        gap_window = 1'b0;
        chk("t2_din_ready_drops", drops, 0);
        chk("t2_out_gaps", gaps, 0);
        chk("t2_out_count", win_outs, 24);

        // Test 3: downstream blocked, 20 offered, 16 accepted
        ready_mode = 0;
        @(negedge clk);
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            din_valid = 1'b1;
            din_real = 12'($urandom);
            din_imag = 12'($urandom);
            if (din_ready) begin
                acc++;
                model_accept(din_real, din_imag);
            end
            @(negedge clk);
        end
        din_valid = 1'b0;
        chk("t3_accepted", acc, 16);
        chk("t3_din_ready_low", din_ready, 0);
        ready_mode = 1;
        wait_drain("t3_drain", 100);
        chk("t3_din_ready_back", din_ready, 1);

        // Test 4: random downstream ready, 4 random frames
        ready_mode = 2;
        for (int i = 0; i < 32; i++) send(12'($urandom), 12'($urandom));
        wait_drain("t4_drain", 1000);
        ready_mode = 1;
        repeat (2) @(negedge clk);

        // Test 5: reset while frame 1 drains and frame 2 is half written
        for (int i = 0; i < 13; i++) send(12'($urandom), 12'($urandom));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("t5_rst_dout", {dout_valid, dout_sop, dout_eop, dout_real, dout_imag}, 0);
        chk("t5_rst_din_ready", din_ready, 1);
        exp_q.delete();
        fbuf.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) send(12'(i), 12'(0 - i));
        wait_drain("t5_drain", 100);

        // Test 6: N=64, values spanning -2048..2047
        n = 0;
        for (int i = 0; i < 64; i++) begin
            v6 = -2048 + i * 65;
            d6_din_valid = 1'b1;
            d6_din_real = 12'(v6);
            d6_din_imag = 12'(0 - v6 - 1);
            if (!d6_din_ready) n++;
            @(negedge clk);
        end
        d6_din_valid = 1'b0;
        chk("t6_din_ready_drops", n, 0);
        n = 0;
        while (!d6_dout_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 64; k++) begin
            v6 = -2048 + brev(k, 6) * 65;
            chk("t6_dout", {d6_dout_valid, d6_dout_real, d6_dout_imag, d6_dout_sop, d6_dout_eop},
                {1'b1, 12'(v6), 12'(0 - v6 - 1), (k == 0), (k == 63)});
            @(negedge clk);
        end
        chk("t6_idle", d6_dout_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
